// File: rtl/dca_matrix_lsu_read_path.sv
// Read-side LSU data path of the DCA matrix engine: issues LPIXM read requests,
// tracks outstanding bursts in order and streams returned (or zero-filled) beats.
module dca_matrix_lsu_read_path #(
  parameter int unsigned BW_AXI_ADDR       = 32,
  parameter int unsigned BW_AXI_DATA       = 32,
  parameter int unsigned BW_AXI_ALEN       = 8,
  parameter int unsigned BW_BITADDR        = 35,
  parameter int unsigned BW_LPI_BURDEN     = 1,
  parameter int unsigned OUTSTANDING_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     is_read_inst,
  input  logic                     txn_valid,
  input  logic [BW_BITADDR-1:0]    txn_bitaddr,
  input  logic [BW_AXI_ALEN-1:0]   txn_alen,
  input  logic                     txn_skip,
  input  logic [BW_LPI_BURDEN-1:0] txn_burden,
  output logic                     txn_ready,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [BW_AXI_ADDR-1:0]   req_addr,
  output logic [BW_AXI_ALEN-1:0]   req_alen,
  output logic [BW_LPI_BURDEN-1:0] req_burden,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [BW_AXI_DATA-1:0]   rsp_data,
  input  logic                     rsp_last,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic [BW_AXI_DATA-1:0]   rdata,
  output logic                     rdata_last,
  output logic                     busy,
  output logic                     err_last
);

  localparam int unsigned BEAT_LSB = $clog2(BW_AXI_DATA / 8);
  localparam int unsigned PTR_W    = $clog2(OUTSTANDING_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(OUTSTANDING_DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_ZERO
  } state_e;

  state_e                   state_q, state_d;
  logic                     req_valid_q, req_valid_d;
  logic [BW_AXI_ADDR-1:0]   req_addr_q, req_addr_d;
  logic [BW_AXI_ALEN-1:0]   req_alen_q, req_alen_d;
  logic [BW_LPI_BURDEN-1:0] req_burden_q, req_burden_d;
  logic [BW_AXI_ALEN-1:0]   beat_q, beat_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  logic                     rdata_valid_q, rdata_valid_d;
  logic                     rdata_last_q, rdata_last_d;
  logic [BW_AXI_DATA-1:0]   rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic                     skip_mem_q [OUTSTANDING_DEPTH];
  logic [BW_AXI_ALEN-1:0]   alen_mem_q [OUTSTANDING_DEPTH];

  logic out_ok;
  logic head_last;
  logic beat_fire;
  logic push;
  logic pop;
  logic tracker_full;
  logic unused_bits;

  assign unused_bits = ^txn_bitaddr[3+BEAT_LSB-1:0];

  always_comb begin
    out_ok    = !rdata_valid_q || rdata_ready;
    head_last = (beat_q == alen_mem_q[rd_ptr_q]);
    rsp_ready = (state_q == ST_BUS) && out_ok;
    beat_fire = ((state_q == ST_BUS) && rsp_valid && out_ok) ||
                ((state_q == ST_ZERO) && out_ok);
    pop       = beat_fire && head_last;
    // A pop in this cycle frees a slot, so a full tracker can still accept.
    tracker_full = (count_q == FULL_CNT) && !pop;
    txn_ready    = !tracker_full && (txn_skip || !req_valid_q || req_ready);
    push         = txn_valid && is_read_inst && txn_ready;

    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_alen_d   = req_alen_q;
    req_burden_d = req_burden_q;
    if (req_valid_q && req_ready) begin
      req_valid_d = 1'b0;
    end
    if (push && !txn_skip) begin
      req_valid_d  = 1'b1;
      req_addr_d   = {txn_bitaddr[BW_BITADDR-1:3+BEAT_LSB], {BEAT_LSB{1'b0}}};
      req_alen_d   = txn_alen;
      req_burden_d = txn_burden;
    end

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // Next state follows whichever entry will be at the head after this edge,
    // bypassing the entry being pushed when it lands in an empty tracker.
    state_d = state_q;
    if (count_d == '0) begin
      state_d = ST_IDLE;
    end else if ((count_q == '0) || (pop && (count_q == ONE_CNT))) begin
      state_d = txn_skip ? ST_ZERO : ST_BUS;
    end else if (pop) begin
      state_d = skip_mem_q[rd_ptr_q + 1'b1] ? ST_ZERO : ST_BUS;
    end

    beat_d        = beat_q;
    rdata_valid_d = rdata_valid_q;
    rdata_d       = rdata_q;
    rdata_last_d  = rdata_last_q;
    err_d         = err_q;
    if (rdata_valid_q && rdata_ready) begin
      rdata_valid_d = 1'b0;
    end
    if (beat_fire) begin
      rdata_valid_d = 1'b1;
      rdata_d       = (state_q == ST_BUS) ? rsp_data : '0;
      rdata_last_d  = head_last;
      beat_d        = head_last ? '0 : beat_q + 1'b1;
      if ((state_q == ST_BUS) && (rsp_last != head_last)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q       <= ST_IDLE;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_alen_q    <= '0;
      req_burden_q  <= '0;
      beat_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_alen_q    <= req_alen_d;
      req_burden_q  <= req_burden_d;
      beat_q        <= beat_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      skip_mem_q[wr_ptr_q] <= txn_skip;
      alen_mem_q[wr_ptr_q] <= txn_alen;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_addr    = req_addr_q;
  assign req_alen    = req_alen_q;
  assign req_burden  = req_burden_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rdata_last_q;
  assign err_last    = err_q;
  assign busy        = (count_q != '0) || req_valid_q || rdata_valid_q;

endmodule

// File: tb/tb_dca_matrix_lsu_read_path.sv
// Scoreboard bench for dca_matrix_lsu_read_path: expected beats and requests are
// queued when a transaction is accepted; monitors pop and compare on handshakes.
module tb_dca_matrix_lsu_read_path;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int BAW = 35;
  localparam int BDW = 1;

  logic           clk = 1'b0;
  logic           rst, clear, is_read_inst;
  logic           txn_valid, txn_skip, txn_ready;
  logic [BAW-1:0] txn_bitaddr;
  logic [LW-1:0]  txn_alen;
  logic [BDW-1:0] txn_burden;
  logic           req_valid, req_ready;
  logic [AW-1:0]  req_addr;
  logic [LW-1:0]  req_alen;
  logic [BDW-1:0] req_burden;
  logic           rsp_valid, rsp_ready, rsp_last;
  logic [DW-1:0]  rsp_data;
  logic           rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0]  rdata;
  logic           busy, err_last;

  dca_matrix_lsu_read_path #(
    .BW_AXI_ADDR(AW), .BW_AXI_DATA(DW), .BW_AXI_ALEN(LW),
    .BW_BITADDR(BAW), .BW_LPI_BURDEN(BDW), .OUTSTANDING_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .is_read_inst(is_read_inst),
    .txn_valid(txn_valid), .txn_bitaddr(txn_bitaddr), .txn_alen(txn_alen),
    .txn_skip(txn_skip), .txn_burden(txn_burden), .txn_ready(txn_ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_alen(req_alen), .req_burden(req_burden),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy), .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [LW-1:0]  alen;
    logic [BDW-1:0] burden;
  } req_t;

  beat_t exp_q[$];
  beat_t rsp_q[$];
  req_t  req_exp_q[$];

  int   checks   = 0;
  int   failures = 0;
  logic err_exp  = 1'b0;
  bit   rsp_hold = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   req_rand = 1'b0;
  bit   rsp_gaps = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: skip -> alen+1 zero beats; bus -> alen+1 bench-chosen words, in acceptance order.
  function automatic void model_push(input logic [BAW-1:0] ba, input int al, input bit sk,
                                     input bit bd, input bit bad);
    beat_t          b;
    req_t           r;
    logic [BAW-1:0] byte_addr;
    if (!sk) begin
      byte_addr = ba >> 3;
      r.addr    = byte_addr[AW-1:0] & ~32'h3;
      r.alen    = LW'(al);
      r.burden  = BDW'(bd);
      req_exp_q.push_back(r);
      if (bad) err_exp = 1'b1;
    end
    for (int i = 0; i <= al; i++) begin
      b.data = sk ? '0 : DW'($urandom);
      b.last = (i == al);
      exp_q.push_back(b);
      if (!sk) begin
        b.last = bad ? ((i == 1) || (i == al)) : (i == al);
        rsp_q.push_back(b);
      end
    end
  endfunction

  // Called and returns at posedge+1.
  task automatic issue_txn(input logic [BAW-1:0] ba, input int al, input bit sk,
                           input bit bd, input bit bad);
    bit ok = 1'b0;
    txn_valid   = 1'b1;
    txn_bitaddr = ba;
    txn_alen    = LW'(al);
    txn_skip    = sk;
    txn_burden  = BDW'(bd);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txn_ready === 1'b1) begin
        model_push(ba, al, sk, bd, bad);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("txn_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    txn_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin : rdata_mon
    beat_t e;
    forever begin
      @(negedge clk);
      if (rdata_valid === 1'b1 && rdata_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdata_unexpected got=0x%0h want=none t=%0t", rdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("rdata", 64'(rdata), 64'(e.data));
          check("rdata_last", 64'(rdata_last), 64'(e.last));
        end
      end
    end
  end

  initial begin : req_mon
    req_t r;
    forever begin
      @(negedge clk);
      if (req_valid === 1'b1 && req_ready === 1'b1) begin
        if (req_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected got=0x%0h want=none t=%0t", req_addr, $time);
        end else begin
          r = req_exp_q.pop_front();
          check("req_addr", 64'(req_addr), 64'(r.addr));
          check("req_alen", 64'(req_alen), 64'(r.alen));
          check("req_burden", 64'(req_burden), 64'(r.burden));
        end
      end
    end
  end

  initial begin : stall_mon
    bit            held = 1'b0;
    logic [DW-1:0] hd;
    logic          hl;
    forever begin
      @(negedge clk);
      if (held) begin
        check("stall_valid", 64'(rdata_valid), 64'd1);
        check("stall_data", 64'(rdata), 64'(hd));
        check("stall_last", 64'(rdata_last), 64'(hl));
      end
      held = (rdata_valid === 1'b1 && rdata_ready === 1'b0);
      hd   = rdata;
      hl   = rdata_last;
    end
  end

  initial begin : latency_mon
    bit            pend = 1'b0;
    logic [DW-1:0] pd;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("rsp_to_rdata_valid", 64'(rdata_valid), 64'd1);
        check("rsp_to_rdata_data", 64'(rdata), 64'(pd));
      end
      pend = (rsp_valid === 1'b1 && rsp_ready === 1'b1);
      pd   = rsp_data;
    end
  end

  initial begin : responder
    bit    fired;
    bit    have = 1'b0;
    beat_t cur;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_last  = 1'b0;
    forever begin
      @(negedge clk);
      fired = (rsp_valid === 1'b1 && rsp_ready === 1'b1);
      @(posedge clk); #1;
      if (fired) have = 1'b0;
      if (!have && rsp_q.size() > 0 && !rsp_hold) begin
        cur  = rsp_q.pop_front();
        have = 1'b1;
      end
      if (have && !(rsp_gaps && $urandom_range(0, 3) == 0)) begin
        rsp_valid = 1'b1;
        rsp_data  = cur.data;
        rsp_last  = cur.last;
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = DW'($urandom);
        rsp_last  = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : ready_drivers
    rdata_ready = 1'b1;
    req_ready   = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdata_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      req_ready   = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    rst          = 1'b1;
    clear        = 1'b0;
    is_read_inst = 1'b1;
    txn_valid    = 1'b0;
    txn_bitaddr  = '0;
    txn_alen     = '0;
    txn_skip     = 1'b0;
    txn_burden   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_req_valid", 64'(req_valid), 64'd0);
    check("reset_req_addr", 64'(req_addr), 64'd0);
    check("reset_rdata_valid", 64'(rdata_valid), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_rdata_last", 64'(rdata_last), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err_last", 64'(err_last), 64'd0);
    check("reset_rsp_ready", 64'(rsp_ready), 64'd0);
    check("reset_txn_ready", 64'(txn_ready), 64'd1);
    @(posedge clk); #1;

    // Single 4-beat read.
    issue_txn(35'h1_0000_0040, 3, 1'b0, 1'b1, 1'b0);
    wait_drain("single_drain");

    // Skip between two single-beat reads.
    issue_txn(35'h0_0000_0100, 0, 1'b0, 1'b0, 1'b0);
    issue_txn(35'h0_0000_0000, 1, 1'b1, 1'b0, 1'b0);
    issue_txn(35'h0_0000_0208, 0, 1'b0, 1'b1, 1'b0);
    wait_drain("skip_drain");

    // Valid without a read opcode must not be accepted.
    is_read_inst = 1'b0;
    txn_valid    = 1'b1;
    txn_skip     = 1'b1;
    txn_alen     = LW'(2);
    repeat (3) @(negedge clk);
    check("noread_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    txn_valid    = 1'b0;
    is_read_inst = 1'b1;

    // Fill the tracker with responses held back.
    rsp_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_txn({3'd0, 32'($urandom)}, 0, 1'b0, 1'(k), 1'b0);
    end
    txn_valid   = 1'b1;
    txn_bitaddr = 35'h0_0000_4000;
    txn_alen    = '0;
    txn_skip    = 1'b0;
    txn_burden  = '0;
    repeat (3) begin
      @(negedge clk);
      check("fill_ready_low", 64'(txn_ready), 64'd0);
    end
    rsp_hold = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txn_ready === 1'b1) begin
        check("fill_ready_at_pop", 64'(rsp_valid === 1'b1 && rsp_ready === 1'b1), 64'd1);
        model_push(35'h0_0000_4000, 0, 1'b0, 1'b0, 1'b0);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("fill_release_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    txn_valid = 1'b0;
    wait_drain("fill_drain");

    // Early rsp_last: sticky error, burst still delivered by count.
    check("err_before", 64'(err_last), 64'(err_exp));
    issue_txn(35'h0_0000_1000, 3, 1'b0, 1'b1, 1'b1);
    wait_drain("err_drain");
    check("err_last_set", 64'(err_last), 64'(err_exp));
    issue_txn(35'h0_0000_2000, 1, 1'b0, 1'b0, 1'b0);
    wait_drain("err_sticky_drain");
    check("err_last_sticky", 64'(err_last), 64'(err_exp));
    check("clear_legal", 64'(exp_q.size() == 0 && rsp_q.size() == 0), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    check("clear_err_last", 64'(err_last), 64'(err_exp));
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_txn_ready", 64'(txn_ready), 64'd1);
    @(posedge clk); #1;

    // Random traffic with stalls on every interface.
    rdy_rand = 1'b1;
    req_rand = 1'b1;
    rsp_gaps = 1'b1;
    for (int n = 0; n < 40; n++) begin
      issue_txn({3'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_drain("rand_drain");
    rdy_rand = 1'b0;
    req_rand = 1'b0;
    rsp_gaps = 1'b0;
    repeat (2) @(negedge clk);
    check("final_busy", 64'(busy), 64'd0);
    check("final_err_last", 64'(err_last), 64'(err_exp));
    check("final_txn_ready", 64'(txn_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
